wb_skid_reg: RTL
================

Name: wb_skid_reg

Overview:
- Registered writeback-operand stage that sits directly upstream of the 4-input writeback mux (mux4).
- Captures the four candidate results and the select code from the MEM stage:
  - a = ALU result
  - b = load data
  - c = PC+4
  - d = immediate
- Presents them to mux4 a/b/c/d/sel with a valid/ready handshake.
- A two-entry skid buffer decouples the MEM stage from register-file write stalls without a combinational ready path.

Parameters:
- WIDTH, 32, data width of each candidate operand
- SEL_W, 2, width of the mux select code
- RD_W, 5, width of the destination register index

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous pipeline flush; discards all held entries
- in_valid  input  1  upstream entry valid
- in_ready  output  1  stage can accept an entry this cycle
- in_a  input  WIDTH  ALU result candidate
- in_b  input  WIDTH  load data candidate
- in_c  input  WIDTH  PC+4 candidate
- in_d  input  WIDTH  immediate candidate
- in_sel  input  SEL_W  writeback select code
- in_rd  input  RD_W  destination register index
- in_we  input  1  register-file write enable
- out_valid  output  1  entry presented to mux4/regfile is valid
- out_ready  input  1  downstream consumes entry this cycle
- out_a, out_b, out_c, out_d  output  WIDTH  to mux4 a/b/c/d
- out_sel  output  SEL_W  to mux4 sel
- out_rd  output  RD_W  regfile write index
- out_we  output  1  regfile write enable, gated: out_we = held_we & out_valid

Behaviour:
- One clock, clk. Reset is asynchronous and active-low (rst_n); polarity and synchronicity are fixed.
- Reset (rst_n low, asynchronous):
  - Main and skid valids clear; all out_* data registers go to 0.
  - out_valid=0, out_we=0, in_ready=1.
  - Inputs are ignored while rst_n is low.
- Storage: main register (drives out_*) and skid register; each carries {a,b,c,d,sel,rd,we} plus a valid bit.
- Transfers:
  - Accept: in_valid & in_ready.
  - Consume: out_valid & out_ready.
- in_ready = ~skid_valid. It is a register output; there is no combinational path from out_ready.
- States:
  - EMPTY: main invalid, skid invalid.
  - ONE: main valid, skid invalid.
  - FULL: both valid.
- Transitions, evaluated at the rising edge with flush=0:
  - EMPTY + accept -> ONE; main <= input.
  - ONE + accept + consume -> ONE; main <= input.
  - ONE + accept, no consume -> FULL; skid <= input; main holds.
  - ONE + consume, no accept -> EMPTY.
  - FULL + consume -> ONE; main <= skid. No accept is possible in FULL because in_ready=0.
  - Any other case: hold.
- Latency: an entry accepted at edge N appears on out_* after edge N when the stage was EMPTY, or when it was ONE with a consume on the same edge.
- Ordering: strictly FIFO; no entry is dropped or duplicated except by flush or reset.
- Stability: while out_valid=1 and out_ready=0, all out_* hold bit-stable.
- Data registers are not cleared on consume. Stale data may remain on out_a..out_d when out_valid=0, but out_we is forced 0.
- Flush (synchronous, highest priority):
  - At the edge it clears both valids.
  - An input accepted on the same cycle is discarded.
  - A consume on the same cycle still counts downstream, because the regfile samples it that cycle.
  - Next cycle: out_valid=0, in_ready=1.
- Reset asserted mid-operation: immediate return to the reset state, including a FULL stage; entries are lost.
- No arithmetic is performed; widths pass through unchanged.

Test Plan:
- Reset, then one entry: a=1, b=2, c=3, d=4, sel=2'b01, rd=5, we=1 with out_ready=1 -> next cycle out_valid=1, out_sel=01, out_we=1, mux4 y=0x00000002; the following cycle out_valid=0, out_we=0.
- Back-pressure: out_ready=0, push entries E1 (a=0x10) then E2 (a=0x20) -> after two edges in_ready=0, out_a=0x10 stable; raise out_ready -> out_a=0x10 then 0x20 on consecutive cycles; in_ready=1 again after the first consume.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles with a=0..7 -> out_a=0..7 on consecutive cycles, no bubbles, in_ready stays 1.
- Flush in FULL with in_valid=1 on the same cycle -> next cycle out_valid=0, out_we=0, in_ready=1; neither entry nor the offered input ever appears.
- Assert rst_n=0 asynchronously mid-cycle while FULL -> out_valid, out_we and all out_* go to 0 immediately; after release in_ready=1.
- Gating: accept an entry with we=0, sel=2'b11, d=0xDEADBEEF -> out_valid=1, out_we=0, mux4 y=0xDEADBEEF.

Source files
------------

// File: rtl/wb_skid_reg.sv
// -----------------------------------------------------------------------------
// wb_skid_reg
//
// Registered writeback-operand stage placed directly in front of the 4-input
// writeback mux (mux4). It captures the four candidate results from the MEM
// stage (a = ALU result, b = load data, c = PC+4, d = immediate) together with
// the select code, destination index and write enable, and presents them to
// mux4/regfile through a valid/ready handshake. A two-entry skid buffer
// (main + skid) absorbs register-file write stalls so that in_ready is a pure
// register decode with no combinational path from out_ready.
//
// Ports:
//   clk                    rising-edge clock
//   rst_n                  asynchronous active-low reset
//   flush                  synchronous flush, discards every held entry
//   in_valid / in_ready    upstream handshake (accept = in_valid & in_ready)
//   in_a..in_d             candidate operands for mux4 a/b/c/d
//   in_sel                 writeback select code
//   in_rd / in_we          destination register index / write enable
//   out_valid / out_ready  downstream handshake (consume = out_valid & out_ready)
//   out_a..out_d, out_sel  to mux4
//   out_rd                 regfile write index
//   out_we                 regfile write enable, forced low when out_valid=0
// -----------------------------------------------------------------------------
module wb_skid_reg #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 2,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_c,
  output logic [WIDTH-1:0] out_d,
  output logic [SEL_W-1:0] out_sel,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_we
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [SEL_W-1:0] sel;
    logic [RD_W-1:0]  rd;
    logic             we;
  } entry_t;

  // Occupancy encoding: bit 0 = main valid, bit 1 = skid valid.
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  logic [1:0] state;
  logic [1:0] state_nxt;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     in_entry;

  logic accept;
  logic consume;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  assign in_entry = '{a: in_a, b: in_b, c: in_c, d: in_d,
                      sel: in_sel, rd: in_rd, we: in_we};

  // Both handshake outputs decode registered state only.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      // A consume on this edge has already been seen by the regfile; an
      // accept on this edge is simply dropped.
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt    = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_nxt = FULL;
            load_skid = 1'b1;
          end else if (consume) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain path exists.
          if (consume) begin
            state_nxt      = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the payload registers are reset even though valid alone would be
  // enough for correctness, because out_* must read 0 during reset; skid is
  // cleared too so no X ever reaches main through the drain path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      // Payloads are not cleared on consume; out_we gating hides stale data.
      if (load_main_in) begin
        main_q <= in_entry;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_entry;
      end
    end
  end

  assign out_a   = main_q.a;
  assign out_b   = main_q.b;
  assign out_c   = main_q.c;
  assign out_d   = main_q.d;
  assign out_sel = main_q.sel;
  assign out_rd  = main_q.rd;
  assign out_we  = main_q.we & out_valid;

endmodule
